// File: rtl/hazard_sb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_sb_ctrl_pkg
//   Shared types for the scoreboard-based hazard controller of the 5-stage
//   MIPS core: register index type, controller FSM states and the bundle of
//   pipeline latch enables/flushes produced each cycle.
// ---------------------------------------------------------------------------
package hazard_sb_ctrl_pkg;

  localparam int HZ_LAT_W = 2;  // default width of a per-register bubble counter
  localparam int REG_W    = 5;  // architectural register index width

  typedef logic [REG_W-1:0] regbits_t;

  // RUN: normal operation. DWAIT: MEM stage is waiting on dmem.
  typedef enum logic {HZ_RUN, HZ_DWAIT} hz_state_t;

  // One cycle's worth of latch controls.
  typedef struct packed {
    logic enable_if;
    logic enable_id;
    logic enable_ex;
    logic enable_mem;
    logic flush_id;
    logic flush_ex;
    logic flush_mem;
  } hz_ctrl_t;

  // Everything advances, nothing is bubbled.
  localparam hz_ctrl_t HZ_CTRL_RUN = '{
    enable_if:  1'b1,
    enable_id:  1'b1,
    enable_ex:  1'b1,
    enable_mem: 1'b1,
    flush_id:   1'b0,
    flush_ex:   1'b0,
    flush_mem:  1'b0
  };

  // Whole pipeline holds: no advance and no bubble insertion.
  localparam hz_ctrl_t HZ_CTRL_FREEZE = '0;

endpackage

// File: rtl/hazard_sb_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_sb_ctrl_if
//   Pipeline <-> hazard controller signal bundle.
//   master : the pipeline; drives ID decode info, EX redirect, memory status,
//            receives the latch enables/flushes.
//   slave  : the hazard controller.
//   Signals:
//     id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wsel, id_wen, id_lat
//                   instruction currently in ID
//     ex_redirect   control transfer resolved in EX
//     dmem_req/dhit MEM-stage data access outstanding / completing
//     ihit          fetch completes this cycle
//     enable_*      latch advance enables (IF/ID, ID/EX, EX/MEM, MEM/WB side)
//     flush_*       latch bubble inserts
// ---------------------------------------------------------------------------
interface hazard_sb_ctrl_if
  import hazard_sb_ctrl_pkg::*;
#(
  parameter int LAT_W = HZ_LAT_W
) ();

  logic             id_valid;
  regbits_t         id_rs;
  regbits_t         id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  regbits_t         id_wsel;
  logic             id_wen;
  logic [LAT_W-1:0] id_lat;
  logic             ex_redirect;
  logic             dmem_req;
  logic             dhit;
  logic             ihit;

  logic             enable_IF;
  logic             enable_ID;
  logic             enable_EX;
  logic             enable_MEM;
  logic             flush_ID;
  logic             flush_EX;
  logic             flush_MEM;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wsel, id_wen, id_lat,
    output ex_redirect, dmem_req, dhit, ihit,
    input  enable_IF, enable_ID, enable_EX, enable_MEM,
    input  flush_ID, flush_EX, flush_MEM
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wsel, id_wen, id_lat,
    input  ex_redirect, dmem_req, dhit, ihit,
    output enable_IF, enable_ID, enable_EX, enable_MEM,
    output flush_ID, flush_EX, flush_MEM
  );

endinterface

// File: rtl/hazard_sb_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   One bubble countdown per architectural register (r0 excluded). A nonzero
//   count means a dependent instruction in ID must still wait that many
//   cycles before it can read the register safely.
//   Ports:
//     CLK, nRST          clock, asynchronous active-low reset
//     freeze             pipeline frozen: all counters hold
//     set_en/idx/val     load a register's countdown (issue of a producer)
//     rd_a_idx/rd_b_idx  two lookup ports (rs, rt)
//     rd_a_busy/rd_b_busy  register still has bubbles outstanding
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_sb_ctrl_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int LAT_W = HZ_LAT_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             freeze,
  input  logic             set_en,
  input  regbits_t         set_idx,
  input  logic [LAT_W-1:0] set_val,
  input  regbits_t         rd_a_idx,
  input  regbits_t         rd_b_idx,
  output logic             rd_a_busy,
  output logic             rd_b_busy
);

  // r0 is hard-wired zero and never needs tracking, so it has no entry.
  logic [LAT_W-1:0] cnt_q [1:NREGS-1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: this array is reset explicitly -- a stale countdown surviving
      // reset would show up as a phantom stall on the first dependent read.
      for (int r = 1; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every counter sees the
      // pre-edge state; blocking would make the result order-dependent.
      for (int r = 1; r < NREGS; r++) begin
        // A fresh issue to this register overrides the decrement.
        if (set_en && (int'(set_idx) == r)) begin
          cnt_q[r] <= set_val;
        end else if (!freeze && (cnt_q[r] != '0)) begin
          cnt_q[r] <= cnt_q[r] - LAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    // NOTE: outputs get a default before the search loop so no path leaves
    // them unassigned; otherwise a latch would be inferred.
    rd_a_busy = 1'b0;
    rd_b_busy = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if ((int'(rd_a_idx) == r) && (cnt_q[r] != '0)) rd_a_busy = 1'b1;
      if ((int'(rd_b_idx) == r) && (cnt_q[r] != '0)) rd_b_busy = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_sb_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_sb_ctrl
//   Pipeline hazard controller. Decides each cycle, in priority order:
//     dmem wait freeze > EX redirect flush > data hazard stall > fetch miss.
//   A register scoreboard holds per-register bubble countdowns so load-use and
//   multi-cycle producers stall ID exactly as long as their latency requires.
//   Also tracks stall/flush perf counters and a sticky dmem-wait watchdog.
//   Ports:
//     CLK, nRST     core clock, asynchronous active-low reset
//     bus           hazard_sb_ctrl_if.slave (ID info, redirect, mem status in;
//                   latch enables/flushes out, all combinational)
//     stall_cycles  cycles with enable_ID low (wraps)
//     flush_count   redirect flushes taken (wraps)
//     timeout_err   sticky, set when a dmem wait lasts DWAIT_MAX cycles
// ---------------------------------------------------------------------------
module hazard_sb_ctrl
  import hazard_sb_ctrl_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int LAT_W     = HZ_LAT_W,
  parameter int PERF_W    = 32,
  parameter int DWAIT_MAX = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  hazard_sb_ctrl_if.slave   bus,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count,
  output logic              timeout_err
);

  localparam int WAIT_W = $clog2(DWAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(DWAIT_MAX);

  hz_state_t         state_q, state_next;
  hz_ctrl_t          ctrl;
  logic              frozen;
  logic              redirect_take;
  logic              issue;
  logic              data_hazard;
  logic              rs_busy, rt_busy;
  logic [WAIT_W-1:0] wait_cnt;

  // ---- scoreboard ---------------------------------------------------------
  hazard_scoreboard #(
    .NREGS (NREGS),
    .LAT_W (LAT_W)
  ) u_scoreboard (
    .CLK       (CLK),
    .nRST      (nRST),
    .freeze    (frozen),
    .set_en    (issue && bus.id_wen && (bus.id_wsel != '0)),
    .set_idx   (bus.id_wsel),
    .set_val   (bus.id_lat),
    .rd_a_idx  (bus.id_rs),
    .rd_b_idx  (bus.id_rt),
    .rd_a_busy (rs_busy),
    .rd_b_busy (rt_busy)
  );

  // r0 is excluded inside the scoreboard, so busy already implies rs/rt != 0.
  assign data_hazard = bus.id_valid &&
                       ((bus.id_use_rs && rs_busy) || (bus.id_use_rt && rt_busy));

  // ---- priority mux -------------------------------------------------------
  always_comb begin
    ctrl          = HZ_CTRL_RUN;
    frozen        = 1'b0;
    redirect_take = 1'b0;
    issue         = 1'b0;
    if (bus.dmem_req && !bus.dhit) begin
      // Everything holds; a pending redirect is re-presented once unfrozen.
      ctrl   = HZ_CTRL_FREEZE;
      frozen = 1'b1;
    end else if (bus.ex_redirect) begin
      ctrl.flush_id = 1'b1;
      ctrl.flush_ex = 1'b1;
      redirect_take = 1'b1;
    end else if (data_hazard) begin
      // Hold IF and ID, send a bubble into EX.
      ctrl.enable_if = 1'b0;
      ctrl.enable_id = 1'b0;
      ctrl.flush_ex  = 1'b1;
    end else begin
      if (!bus.ihit) begin
        // Fetch not ready: bubble into ID but let the current ID proceed.
        ctrl.enable_if = 1'b0;
        ctrl.flush_id  = 1'b1;
      end
      issue = bus.id_valid;
    end
  end

  assign bus.enable_IF  = ctrl.enable_if;
  assign bus.enable_ID  = ctrl.enable_id;
  assign bus.enable_EX  = ctrl.enable_ex;
  assign bus.enable_MEM = ctrl.enable_mem;
  assign bus.flush_ID   = ctrl.flush_id;
  assign bus.flush_EX   = ctrl.flush_ex;
  assign bus.flush_MEM  = ctrl.flush_mem;

  // ---- FSM ----------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= HZ_RUN;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      HZ_RUN:   if (bus.dmem_req && !bus.dhit) state_next = HZ_DWAIT;
      HZ_DWAIT: if (bus.dhit)                  state_next = HZ_RUN;
    endcase
  end

  // ---- watchdog -----------------------------------------------------------
  // Counts every cycle spent in (or entering) DWAIT, so a wait of DWAIT_MAX
  // cycles including the entry cycle is what trips the sticky error.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (state_next == HZ_DWAIT) begin
      if (wait_cnt != WAIT_TOP) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt >= WAIT_TOP - WAIT_W'(1)) timeout_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // ---- perf counters (free-running, wrap) ---------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!ctrl.enable_id) stall_cycles <= stall_cycles + PERF_W'(1);
      if (redirect_take)   flush_count  <= flush_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_sb_ctrl
//   Directed stimulus for hazard_sb_ctrl. The driver pushes the hand-computed
//   expected controls/counters for each cycle into a queue; a monitor on the
//   falling edge pops and compares against what the DUT presents.
//   Control vector order: {enable_IF, enable_ID, enable_EX, enable_MEM,
//                          flush_ID, flush_EX, flush_MEM}.
//   Counters are compared as seen before the cycle's own rising edge.
// ---------------------------------------------------------------------------
module tb_hazard_sb_ctrl;
  import hazard_sb_ctrl_pkg::*;

  localparam int DWAIT_MAX = 255;

  localparam logic [6:0] C_RUN  = 7'b1111_000;
  localparam logic [6:0] C_FRZ  = 7'b0000_000;
  localparam logic [6:0] C_RED  = 7'b1111_110;
  localparam logic [6:0] C_HAZ  = 7'b0011_010;
  localparam logic [6:0] C_MISS = 7'b0111_100;

  logic        CLK  = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic        timeout_err;

  hazard_sb_ctrl_if #(.LAT_W(2)) bus ();

  hazard_sb_ctrl #(
    .NREGS     (32),
    .LAT_W     (2),
    .PERF_W    (32),
    .DWAIT_MAX (DWAIT_MAX)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .bus          (bus),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .timeout_err  (timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    int         stall;
    int         flush;
    logic       to;
    bit         chk_st;
    hz_state_t  st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // ---- monitor ------------------------------------------------------------
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, "/ctrl"},
            64'({bus.enable_IF, bus.enable_ID, bus.enable_EX, bus.enable_MEM,
                 bus.flush_ID, bus.flush_EX, bus.flush_MEM}),
            64'(mon_e.ctrl));
      check({mon_e.name, "/stall_cycles"}, 64'(stall_cycles), 64'(mon_e.stall));
      check({mon_e.name, "/flush_count"},  64'(flush_count),  64'(mon_e.flush));
      check({mon_e.name, "/timeout_err"},  64'(timeout_err),  64'(mon_e.to));
      if (mon_e.chk_st) check({mon_e.name, "/state"}, 64'(dut.state_q), 64'(mon_e.st));
    end
  end

  // ---- driver helpers -----------------------------------------------------
  task automatic idle_inputs();
    bus.id_valid    = 1'b0;
    bus.id_rs       = '0;
    bus.id_rt       = '0;
    bus.id_use_rs   = 1'b0;
    bus.id_use_rt   = 1'b0;
    bus.id_wsel     = '0;
    bus.id_wen      = 1'b0;
    bus.id_lat      = '0;
    bus.ex_redirect = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dhit        = 1'b0;
    bus.ihit        = 1'b1;
  endtask

  task automatic push_exp(input string name, input logic [6:0] c, input int s, input int f,
                          input logic to, input bit chk_st, input hz_state_t st);
    exp_t e;
    e.name   = name;
    e.ctrl   = c;
    e.stall  = s;
    e.flush  = f;
    e.to     = to;
    e.chk_st = chk_st;
    e.st     = st;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive all inputs just after the rising edge, queue the
  // expectation for the following falling edge.
  task automatic cyc(input string name,
                     input logic v, input int rs, input int rt, input logic urs, input logic urt,
                     input int wsel, input logic wen, input int lat,
                     input logic redir, input logic dreq, input logic dh, input logic ih,
                     input logic [6:0] c, input int s, input int f, input logic to,
                     input bit chk_st, input hz_state_t st);
    @(posedge CLK);
    #1;
    bus.id_valid    = v;
    bus.id_rs       = 5'(rs);
    bus.id_rt       = 5'(rt);
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.id_wsel     = 5'(wsel);
    bus.id_wen      = wen;
    bus.id_lat      = 2'(lat);
    bus.ex_redirect = redir;
    bus.dmem_req    = dreq;
    bus.dhit        = dh;
    bus.ihit        = ih;
    push_exp(name, c, s, f, to, chk_st, st);
  endtask

  // Assert reset between clock edges and check the outputs before any
  // rising edge has occurred, then release.
  task automatic pulse_reset(input string name);
    @(posedge CLK);
    #2;
    idle_inputs();
    nRST = 1'b0;
    push_exp(name, C_RUN, 0, 0, 1'b0, 1'b1, HZ_RUN);
    @(negedge CLK);
    #2;
    nRST = 1'b1;
  endtask

  // ---- stimulus -----------------------------------------------------------
  initial begin
    idle_inputs();
    push_exp("reset", C_RUN, 0, 0, 1'b0, 1'b1, HZ_RUN);
    @(negedge CLK);
    #2;
    nRST = 1'b1;

    //   name          v rs rt urs urt ws wen lat  rd dq dh ih  ctrl   S  F  to chk st
    // load-use: exactly one stall cycle
    cyc("t1_lw",       1, 0, 0, 0, 0,  8, 1, 1,   0, 0, 0, 1, C_RUN, 0, 0, 0, 0, HZ_RUN);
    cyc("t1_dep_stall",1, 8, 0, 1, 0,  0, 0, 0,   0, 0, 0, 1, C_HAZ, 0, 0, 0, 0, HZ_RUN);
    cyc("t1_dep_issue",1, 8, 0, 1, 0,  0, 0, 0,   0, 0, 0, 1, C_RUN, 1, 0, 0, 0, HZ_RUN);
    // ALU producer and r0 writes never stall
    cyc("t2_add",      1, 0, 0, 0, 0,  8, 1, 0,   0, 0, 0, 1, C_RUN, 1, 0, 0, 0, HZ_RUN);
    cyc("t2_dep",      1, 8, 0, 1, 0,  0, 0, 0,   0, 0, 0, 1, C_RUN, 1, 0, 0, 0, HZ_RUN);
    cyc("t2_wr_r0",    1, 0, 0, 0, 0,  0, 1, 3,   0, 0, 0, 1, C_RUN, 1, 0, 0, 0, HZ_RUN);
    cyc("t2_dep_r0",   1, 0, 0, 1, 1,  0, 0, 0,   0, 0, 0, 1, C_RUN, 1, 0, 0, 0, HZ_RUN);
    // load to r9, then a 5-cycle dmem freeze; countdown must hold
    cyc("t3_lw9",      1, 0, 0, 0, 0,  9, 1, 1,   0, 0, 0, 1, C_RUN, 1, 0, 0, 0, HZ_RUN);
    cyc("t3_frz1",     1, 9, 0, 1, 0,  0, 0, 0,   0, 1, 0, 1, C_FRZ, 1, 0, 0, 1, HZ_RUN);
    cyc("t3_frz2",     1, 9, 0, 1, 0,  0, 0, 0,   0, 1, 0, 1, C_FRZ, 2, 0, 0, 1, HZ_DWAIT);
    cyc("t3_frz3",     1, 9, 0, 1, 0,  0, 0, 0,   0, 1, 0, 1, C_FRZ, 3, 0, 0, 1, HZ_DWAIT);
    cyc("t3_frz4",     1, 9, 0, 1, 0,  0, 0, 0,   0, 1, 0, 1, C_FRZ, 4, 0, 0, 1, HZ_DWAIT);
    cyc("t3_frz5",     1, 9, 0, 1, 0,  0, 0, 0,   0, 1, 0, 1, C_FRZ, 5, 0, 0, 1, HZ_DWAIT);
    cyc("t3_dhit",     1, 9, 0, 1, 0,  0, 0, 0,   0, 1, 1, 1, C_HAZ, 6, 0, 0, 1, HZ_DWAIT);
    cyc("t3_issue",    1, 9, 0, 1, 0,  0, 0, 0,   0, 0, 0, 1, C_RUN, 7, 0, 0, 1, HZ_RUN);
    // redirect beats a data hazard; the blocked writer must not issue
    cyc("t4_lw10",     1, 0, 0, 0, 0, 10, 1, 2,   0, 0, 0, 1, C_RUN, 7, 0, 0, 0, HZ_RUN);
    cyc("t4_redir",    1, 0,10, 0, 1, 11, 1, 3,   1, 0, 0, 1, C_RED, 7, 0, 0, 0, HZ_RUN);
    cyc("t4_r11_free", 1,11, 0, 1, 0,  0, 0, 0,   0, 0, 0, 1, C_RUN, 7, 1, 0, 0, HZ_RUN);
    cyc("t4_fmiss",    1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, C_MISS,7, 1, 0, 0, HZ_RUN);
    // redirect during freeze is ignored until unfrozen
    cyc("t4_frz_redir",0, 0, 0, 0, 0,  0, 0, 0,   1, 1, 0, 1, C_FRZ, 7, 1, 0, 0, HZ_RUN);
    cyc("t4_redir2",   0, 0, 0, 0, 0,  0, 0, 0,   1, 1, 1, 1, C_RED, 8, 1, 0, 1, HZ_DWAIT);
    cyc("t4_idle",     0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1, C_RUN, 8, 2, 0, 1, HZ_RUN);

    // watchdog: DWAIT_MAX wait cycles trip the sticky error
    for (int k = 1; k <= DWAIT_MAX; k++) begin
      cyc($sformatf("t5_wait%0d", k),
          0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, C_FRZ, 8 + k - 1, 2, 1'b0, (k > 1), HZ_DWAIT);
    end
    cyc("t5_dhit",     0, 0, 0, 0, 0,  0, 0, 0,   0, 1, 1, 1, C_RUN, 8 + DWAIT_MAX, 2, 1, 1, HZ_DWAIT);
    cyc("t5_sticky",   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1, C_RUN, 8 + DWAIT_MAX, 2, 1, 1, HZ_RUN);
    pulse_reset("t5_reset");

    // reset mid-DWAIT with a live countdown on r4
    cyc("t6_lw4",      1, 0, 0, 0, 0,  4, 1, 3,   0, 0, 0, 1, C_RUN, 0, 0, 0, 0, HZ_RUN);
    cyc("t6_frz1",     0, 0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, C_FRZ, 0, 0, 0, 1, HZ_RUN);
    cyc("t6_frz2",     0, 0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, C_FRZ, 1, 0, 0, 1, HZ_DWAIT);
    pulse_reset("t6_reset");
    cyc("t6_dep_rs4",  1, 4, 0, 1, 0,  0, 0, 0,   0, 0, 0, 1, C_RUN, 0, 0, 0, 1, HZ_RUN);
    cyc("t6_dep_rt4",  1, 0, 4, 0, 1,  0, 0, 0,   0, 0, 0, 1, C_RUN, 0, 0, 0, 1, HZ_RUN);

    @(posedge CLK);
    #1;
    idle_inputs();
    repeat (3) @(negedge CLK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #100000;
    $display("FAIL global_timeout: got time %0t expected completion before 100000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
